// File: rtl/risk_pkg.sv
// risk_pkg: shared types for the downstream risk gate.
//   op_e        - operation codes carried on in_op / resp_op
//   resp_code_e - reject / status codes carried on resp_code
//   state_e     - gate FSM states
// The {max, accum} table entry type depends on the per-instance AMOUNT_W, so it
// is declared as risk_entry_t inside the top module. The defaults below give
// its default shape.
package risk_pkg;

  localparam int DEF_CLIENT_W = 5;
  localparam int DEF_AMOUNT_W = 32;

  typedef enum logic [1:0] {
    OP_ORDER   = 2'd0,
    OP_SET_MAX = 2'd1,
    OP_CANCEL  = 2'd2,
    OP_CLEAR   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RC_OK          = 2'd0,
    RC_OVER_LIMIT  = 2'd1,
    RC_ZERO_AMOUNT = 2'd2,
    RC_RSVD        = 2'd3
  } resp_code_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_RESP
  } state_e;

endpackage

// File: rtl/downstream_risk_gate_if.sv
// downstream_risk_gate_if: request / response bundle of the risk gate.
//   in_valid/in_ready          - request handshake
//   in_op/in_client/in_amount  - request payload
//   resp_valid                 - one-cycle response strobe
//   resp_op/client/amount      - echoed request
//   resp_accept/code/accum     - decision and the client's resulting accumulator
// master = requester, slave = gate.
interface downstream_risk_gate_if #(
  parameter int CLIENT_W = 5,
  parameter int AMOUNT_W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_op;
  logic [CLIENT_W-1:0] in_client;
  logic [AMOUNT_W-1:0] in_amount;
  logic                resp_valid;
  logic [1:0]          resp_op;
  logic [CLIENT_W-1:0] resp_client;
  logic [AMOUNT_W-1:0] resp_amount;
  logic                resp_accept;
  logic [1:0]          resp_code;
  logic [AMOUNT_W-1:0] resp_accum;

  modport master (
    output in_valid, in_op, in_client, in_amount,
    input  in_ready, resp_valid, resp_op, resp_client, resp_amount,
           resp_accept, resp_code, resp_accum
  );

  modport slave (
    input  in_valid, in_op, in_client, in_amount,
    output in_ready, resp_valid, resp_op, resp_client, resp_amount,
           resp_accept, resp_code, resp_accum
  );
endinterface

// File: rtl/risk_table.sv
// risk_table: per-client {max, accum} storage, simple dual-port synchronous RAM.
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address, data appears on rdata_o one cycle later
//   rdata_o  - registered read data
// The array has no reset; the gate's INIT sweep clears it.
module risk_table #(
  parameter int AW = 5,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/downstream_risk_gate.sv
// downstream_risk_gate: per-client pre-trade risk gate, one operation per 4 cycles.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset; restarts the table clearing sweep
//   bus   - request/response bundle (slave side), see downstream_risk_gate_if
// Flow: IDLE latches the request and issues the table read, READ registers
// the entry, CHECK decides and writes back, RESP strobes the response.
module downstream_risk_gate
  import risk_pkg::*;
#(
  parameter int CLIENT_W = 5,
  parameter int AMOUNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  downstream_risk_gate_if.slave bus
);
  localparam int N_CLIENTS = 2**CLIENT_W;

  typedef struct packed {
    logic [AMOUNT_W-1:0] max;
    logic [AMOUNT_W-1:0] accum;
  } risk_entry_t;

  state_e              state_q, state_d;
  logic [CLIENT_W-1:0] cnt_q;
  op_e                 op_q;
  logic [CLIENT_W-1:0] client_q;
  logic [AMOUNT_W-1:0] amount_q;
  risk_entry_t         entry_q, rd_entry, entry_d;
  logic [AMOUNT_W:0]   sum;
  logic                accept_d;
  resp_code_e          code_d;

  logic                we;
  logic [CLIENT_W-1:0] waddr;
  risk_entry_t         wdata;
  logic [2*AMOUNT_W-1:0] tbl_rdata;

  logic                resp_valid_q, resp_accept_q;
  resp_code_e          resp_code_q;
  op_e                 resp_op_q;
  logic [CLIENT_W-1:0] resp_client_q;
  logic [AMOUNT_W-1:0] resp_amount_q, resp_accum_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  if (cnt_q == CLIENT_W'(N_CLIENTS-1)) state_d = ST_IDLE;
      ST_IDLE:  if (bus.in_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_CHECK;
      ST_CHECK: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  // Sweep counter: wraps back to 0 as INIT exits, ready for the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt_q <= '0;
    else if (state_q == ST_INIT) cnt_q <= cnt_q + CLIENT_W'(1);
  end

  // ---------------- request latch / entry register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ORDER;
      client_q <= '0;
      amount_q <= '0;
      entry_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.in_valid) begin
        op_q     <= op_e'(bus.in_op);
        client_q <= bus.in_client;
        amount_q <= bus.in_amount;
      end
      if (state_q == ST_READ) entry_q <= rd_entry;
    end
  end

  // ---------------- decision ----------------
  // Sum is one bit wider so an order near the top of the range cannot wrap
  // past the limit check.
  always_comb begin
    sum      = {1'b0, entry_q.accum} + {1'b0, amount_q};
    entry_d  = entry_q;
    accept_d = 1'b1;
    code_d   = RC_OK;
    case (op_q)
      OP_ORDER: begin
        if (amount_q == '0) begin
          accept_d = 1'b0;
          code_d   = RC_ZERO_AMOUNT;
        end else if (sum > {1'b0, entry_q.max}) begin
          accept_d = 1'b0;
          code_d   = RC_OVER_LIMIT;
        end else begin
          entry_d.accum = sum[AMOUNT_W-1:0];
        end
      end
      OP_SET_MAX: entry_d.max = amount_q;
      OP_CANCEL:  entry_d.accum = (entry_q.accum > amount_q) ? entry_q.accum - amount_q : '0;
      default:    entry_d.accum = '0;
    endcase
  end

  // ---------------- table ----------------
  always_comb begin
    we    = 1'b0;
    waddr = client_q;
    wdata = entry_d;
    if (state_q == ST_INIT) begin
      we    = 1'b1;
      waddr = cnt_q;
      wdata = '0;
    end else if (state_q == ST_CHECK && accept_d) begin
      we = 1'b1;
    end
  end

  // Read address follows the request bus; only the read taken on the
  // acceptance edge is consumed (in READ).
  risk_table #(.AW(CLIENT_W), .DW(2*AMOUNT_W)) u_table (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (bus.in_client),
    .rdata_o (tbl_rdata)
  );

  assign rd_entry = tbl_rdata;

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q  <= 1'b0;
      resp_accept_q <= 1'b0;
      resp_code_q   <= RC_OK;
      resp_op_q     <= OP_ORDER;
      resp_client_q <= '0;
      resp_amount_q <= '0;
      resp_accum_q  <= '0;
    end else begin
      resp_valid_q <= (state_q == ST_CHECK);
      if (state_q == ST_CHECK) begin
        resp_accept_q <= accept_d;
        resp_code_q   <= code_d;
        resp_op_q     <= op_q;
        resp_client_q <= client_q;
        resp_amount_q <= amount_q;
        resp_accum_q  <= entry_d.accum;
      end
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_accept = resp_accept_q;
  assign bus.resp_code   = resp_code_q;
  assign bus.resp_op     = resp_op_q;
  assign bus.resp_client = resp_client_q;
  assign bus.resp_amount = resp_amount_q;
  assign bus.resp_accum  = resp_accum_q;
endmodule

// File: tb/tb_downstream_risk_gate.sv
module tb_downstream_risk_gate;
  localparam logic [1:0] ORD = 2'd0, SMX = 2'd1, CAN = 2'd2, CLR = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  downstream_risk_gate_if #(.CLIENT_W(5), .AMOUNT_W(32)) bus  ();
  downstream_risk_gate_if #(.CLIENT_W(3), .AMOUNT_W(8))  bus8 ();

  downstream_risk_gate #(.CLIENT_W(5), .AMOUNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  downstream_risk_gate #(.CLIENT_W(3), .AMOUNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sel;   // 0: 32-client/32-bit gate, 1: 8-client/8-bit gate
    logic [1:0]  op;
    logic [4:0]  cl;
    logic [31:0] amt;
    logic        acc;
    logic [1:0]  code;
    logic [31:0] accum;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic v, input logic [1:0] op,
                       input logic [4:0] cl, input logic [31:0] amt);
    if (sel) begin
      bus8.in_valid = v; bus8.in_op = op; bus8.in_client = cl[2:0]; bus8.in_amount = amt[7:0];
    end else begin
      bus.in_valid = v; bus.in_op = op; bus.in_client = cl; bus.in_amount = amt;
    end
  endtask

  task automatic sample(input logic sel, output logic rv, output logic rdy, output logic [1:0] op,
                        output logic [4:0] cl, output logic [31:0] amt, output logic acc,
                        output logic [1:0] code, output logic [31:0] accum);
    if (sel) begin
      rv = bus8.resp_valid; rdy = bus8.in_ready; op = bus8.resp_op;
      cl = {2'b0, bus8.resp_client}; amt = {24'b0, bus8.resp_amount};
      acc = bus8.resp_accept; code = bus8.resp_code; accum = {24'b0, bus8.resp_accum};
    end else begin
      rv = bus.resp_valid; rdy = bus.in_ready; op = bus.resp_op;
      cl = bus.resp_client; amt = bus.resp_amount;
      acc = bus.resp_accept; code = bus.resp_code; accum = bus.resp_accum;
    end
  endtask

  // Issue one op at a negedge, expect its response 3 edges after acceptance.
  task automatic run_op(input string name, input logic sel, input logic [1:0] op,
                        input logic [4:0] cl, input logic [31:0] amt, input logic eacc,
                        input logic [1:0] ecode, input logic [31:0] eaccum);
    logic rv, rdy, acc;
    logic [1:0] rop, code;
    logic [4:0] rcl;
    logic [31:0] ramt, raccum;
    int n;
    n = 0;
    sample(sel, rv, rdy, rop, rcl, ramt, acc, code, raccum);
    while (!rdy && n < 100) begin
      @(negedge clk); n++;
      sample(sel, rv, rdy, rop, rcl, ramt, acc, code, raccum);
    end
    chk({name, " ready"}, 64'(rdy), 64'd1);
    if (!rdy) return;
    drive(sel, 1'b1, op, cl, amt);
    @(negedge clk);
    drive(sel, 1'b0, op, cl, amt);
    n = 1;
    sample(sel, rv, rdy, rop, rcl, ramt, acc, code, raccum);
    while (!rv && n < 10) begin
      @(negedge clk); n++;
      sample(sel, rv, rdy, rop, rcl, ramt, acc, code, raccum);
    end
    chk({name, " latency"}, 64'(n), 64'd3);
    chk({name, " accept"}, 64'(acc), 64'(eacc));
    chk({name, " code"}, 64'(code), 64'(ecode));
    chk({name, " accum"}, 64'(raccum), 64'(eaccum));
    chk({name, " echo op"}, 64'(rop), 64'(op));
    chk({name, " echo client"}, 64'(rcl), 64'(cl));
    chk({name, " echo amount"}, 64'(ramt), 64'(amt));
    @(negedge clk);
    sample(sel, rv, rdy, rop, rcl, ramt, acc, code, raccum);
    chk({name, " pulse width"}, 64'(rv), 64'd0);
    chk({name, " ready after"}, 64'(rdy), 64'd1);
  endtask

  // Called right after rst_n rises at a negedge.
  task automatic check_init(input string name);
    int n32, n8;
    n32 = -1; n8 = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.in_ready  && n32 < 0) n32 = c;
      if (bus8.in_ready && n8  < 0) n8  = c;
    end
    chk({name, " init cycles 32"}, 64'(n32), 64'd32);
    chk({name, " init cycles 8"},  64'(n8),  64'd8);
  endtask

  initial begin
    int    rcount;
    int    idx[$];
    logic  seen;
    drive(0, 0, ORD, 0, 0);
    drive(1, 0, ORD, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst in_ready",    64'(bus.in_ready),    64'd0);
    chk("rst resp_valid",  64'(bus.resp_valid),  64'd0);
    chk("rst resp_accept", 64'(bus.resp_accept), 64'd0);
    chk("rst resp_code",   64'(bus.resp_code),   64'd0);
    chk("rst resp_op",     64'(bus.resp_op),     64'd0);
    chk("rst resp_client", 64'(bus.resp_client), 64'd0);
    chk("rst resp_amount", 64'(bus.resp_amount), 64'd0);
    chk("rst resp_accum",  64'(bus.resp_accum),  64'd0);
    chk("rst in_ready 8",  64'(bus8.in_ready),   64'd0);
    rst_n = 1'b1;
    check_init("boot");

    // Every entry cleared: ORDER 1 against max 0 rejects with accum 0.
    for (int c = 0; c < 32; c++) run_op($sformatf("clr32 c%0d", c), 0, ORD, 5'(c), 1, 0, 2'd1, 0);
    for (int c = 0; c < 8; c++)  run_op($sformatf("clr8 c%0d", c),  1, ORD, 5'(c), 1, 0, 2'd1, 0);

    vecs = '{
      '{0, SMX, 3, 100, 1, 0, 0},
      '{0, ORD, 3, 60, 1, 0, 60},
      '{0, ORD, 3, 40, 1, 0, 100},               // sum == max
      '{0, ORD, 3, 1, 0, 1, 100},
      '{0, ORD, 7, 0, 0, 2, 0},                  // zero amount
      '{0, CAN, 3, 150, 1, 0, 0},                // saturate
      '{0, ORD, 3, 70, 1, 0, 70},
      '{0, CAN, 3, 20, 1, 0, 50},
      '{0, CLR, 3, 0, 1, 0, 0},
      '{0, ORD, 3, 100, 1, 0, 100},              // max survived CLEAR
      '{0, CLR, 3, 0, 1, 0, 0},
      '{0, ORD, 3, 50, 1, 0, 50},
      '{0, SMX, 3, 10, 1, 0, 50},                // accum above new max kept
      '{0, ORD, 3, 1, 0, 1, 50},
      '{0, SMX, 5, 10, 1, 0, 0},
      '{0, ORD, 5, 11, 0, 1, 0},                 // max + 1
      '{0, ORD, 7, 5, 0, 1, 0},
      '{0, SMX, 31, 32'hFFFF_FFFF, 1, 0, 0},
      '{0, ORD, 31, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF},
      '{0, ORD, 31, 1, 0, 1, 32'hFFFF_FFFF},     // no wrap past full scale
      '{0, CLR, 31, 1234, 1, 0, 0},
      '{0, ORD, 31, 5, 1, 0, 5},
      '{0, CAN, 31, 5, 1, 0, 0},
      '{1, SMX, 5, 255, 1, 0, 0},
      '{1, ORD, 5, 255, 1, 0, 255},
      '{1, ORD, 5, 1, 0, 1, 255},
      '{1, ORD, 7, 1, 0, 1, 0},
      '{1, CAN, 5, 55, 1, 0, 200}
    };
    foreach (vecs[i])
      run_op($sformatf("v%0d", i), vecs[i].sel, vecs[i].op, vecs[i].cl, vecs[i].amt,
             vecs[i].acc, vecs[i].code, vecs[i].accum);

    // Back-to-back: in_valid held high, responses every 4 cycles.
    drive(0, 1, SMX, 9, 77);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        idx.push_back(c);
        chk($sformatf("b2b c%0d op", c),     64'(bus.resp_op),     64'(SMX));
        chk($sformatf("b2b c%0d client", c), 64'(bus.resp_client), 64'd9);
        chk($sformatf("b2b c%0d amount", c), 64'(bus.resp_amount), 64'd77);
        chk($sformatf("b2b c%0d accept", c), 64'(bus.resp_accept), 64'd1);
      end
    end
    drive(0, 0, SMX, 9, 77);
    chk("b2b count", 64'(idx.size()), 64'd5);
    foreach (idx[k]) chk($sformatf("b2b resp%0d cycle", k), 64'(idx[k]), 64'(2 + 4*k));
    @(negedge clk);

    // Reset during CHECK: no response, sweep repeats and clears the table.
    run_op("pre-rst", 0, ORD, 9, 0, 0, 2'd2, 0);
    drive(0, 1, ORD, 3, 1);
    @(negedge clk);            // READ
    drive(0, 0, ORD, 3, 1);
    @(negedge clk);            // CHECK
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    chk("midrst no resp", 64'(seen), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    check_init("midrst");
    run_op("post c3",  0, ORD, 3, 1, 0, 2'd1, 0);
    run_op("post c31", 0, ORD, 31, 1, 0, 2'd1, 0);
    run_op("post c9",  0, ORD, 9, 1, 0, 2'd1, 0);
    run_op("post8 c5", 1, ORD, 5, 1, 0, 2'd1, 0);

    rcount = checks;
    if (rcount < 12) begin
      errors++;
      $display("FAIL check count: got %0d expected at least 12", rcount);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
